axi_slave_mem_responder: RTL and testbench
==========================================

Name:
axi_slave_mem_responder

Overview:
Parametrised, synthesizable AXI slave endpoint that terminates one NoC slave port (S0..S6) with a word-addressed local memory. It accepts write and read bursts, stores and returns data with byte strobes, and generates B and R responses, including SLVERR for out-of-range addresses. It replaces per-slave fixed-width bench responders; data width, ID width, depth and base address are generalised, and FIXED/INCR/WRAP bursts are supported.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a power of 2 and ≥8; BYTES = DATA_WIDTH/8
ADDR_WIDTH, 32, address width
ID_WIDTH, 4, transaction ID width (slave-side ID)
MEM_WORDS, 1024, memory depth in DATA_WIDTH words
BASE_ADDR, 0, byte address of word 0; must be BYTES-aligned

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
S_AWID  in  ID_WIDTH  write ID
S_AWADDR  in  ADDR_WIDTH  write start byte address
S_AWLEN  in  4  beats-1 (0..15)
S_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
S_AWVALID  in  1  AW valid
S_AWREADY  out  1  AW ready
S_WDATA  in  DATA_WIDTH  write data
S_WSTRB  in  BYTES  byte enables
S_WLAST  in  1  last write beat
S_WVALID  in  1  W valid
S_WREADY  out  1  W ready
S_BID  out  ID_WIDTH  response ID
S_BRESP  out  2  00 OKAY, 10 SLVERR
S_BVALID  out  1  B valid
S_BREADY  in  1  B ready
S_ARID  in  ID_WIDTH  read ID
S_ARADDR  in  ADDR_WIDTH  read start byte address
S_ARLEN  in  4  beats-1
S_ARBURST  in  2  burst type
S_ARVALID  in  1  AR valid
S_ARREADY  out  1  AR ready
S_RID  out  ID_WIDTH  read ID
S_RDATA  out  DATA_WIDTH  read data
S_RRESP  out  2  per-beat response
S_RLAST  out  1  last read beat
S_RVALID  out  1  R valid
S_RREADY  in  1  R ready

Behaviour:
- Reset (async, ARESET=1): all outputs 0 immediately; both FSMs go to IDLE; in-flight bursts are dropped; memory contents are not reset and retain any partial writes. Ready outputs are registered, so S_AWREADY and S_ARREADY rise on the first ACLK edge after ARESET falls.
- Independent write FSM W_IDLE→W_DATA→W_RESP and read FSM R_IDLE→R_DATA. Each FSM allows one outstanding transaction; the read and write FSMs operate concurrently.
- W_IDLE: S_AWREADY=1. On the AW handshake, latch ID, address, LEN and BURST, clear the beat counter and error flag, drop AWREADY, go to W_DATA with S_WREADY=1 on the next cycle.
- W_DATA: on each W handshake, write the bytes with WSTRB=1 to word (addr-BASE_ADDR)/BYTES if the address is in range [BASE_ADDR, BASE_ADDR+MEM_WORDS*BYTES); otherwise set the error flag and perform no write. Low address bits below BYTES are ignored. Set the error flag when WLAST disagrees with (beat==LEN). The burst ends on beat==LEN: go to W_RESP with S_WREADY=0, S_BVALID=1 on the next cycle, and S_BRESP=10 if the error flag is set, else 00.
- W_RESP: hold BID/BRESP/BVALID stable until S_BREADY; then go to W_IDLE with BVALID=0 and AWREADY=1 on the next cycle.
- R_IDLE: S_ARREADY=1. On the AR handshake, latch the fields, go to R_DATA, and present beat 0 on the next cycle with RVALID=1, RID, RLAST=(LEN==0), and RDATA/RRESP from the current address. An out-of-range beat gives RDATA=0 and RRESP=10; otherwise RRESP=00.
- R_DATA: R outputs stay stable while RVALID&&!RREADY. On a handshake, advance the address and present the next beat on the next cycle. After the handshake with RLAST=1, go to R_IDLE with RVALID=0 and ARREADY=1 on the next cycle.
- Address advance: FIXED holds the address; INCR adds BYTES; WRAP wraps within the aligned block of (LEN+1)*BYTES bytes. WRAP with LEN not in {1,3,7,15} is treated as INCR and every beat of that burst is SLVERR. Address arithmetic is ADDR_WIDTH modulo 2^ADDR_WIDTH; a wrapped-around address is then range-checked normally.
- Read-after-write: a read beat sampled after the write beat's ACLK edge returns the new data; there is no reordering.

Test Plan:
- INCR write AWLEN=3 at BASE+0x10, data A0..A3, WSTRB=F → BRESP=00 with BID matching AWID; INCR read ARLEN=3 at same address → A0..A3, RLAST only on 4th beat, RRESP=00.
- Word holds 0xFFFFFFFF; write 0x12345678 with WSTRB=0101 → read returns 0xFF34FF78.
- WRAP AWLEN=3 at BASE+0x8 (DATA_WIDTH=32) → beats written to 0x8, 0xC, 0x0, 0x4; readback confirms.
- Read ARLEN=1 at BASE+MEM_WORDS*4 → 2 beats with RDATA=0, RRESP=10, RLAST on 2nd; write to the same address → BRESP=10 and memory unchanged.
- RREADY held low 5 cycles mid-burst → RVALID, RDATA, RID and RLAST stable; BREADY held low 3 cycles → BVALID/BRESP held.
- ARESET pulsed after 2 of 4 write beats → all outputs 0 immediately; after release AWREADY=1 next edge; the 2 completed beats are still readable.

Source files
------------

// File: rtl/axi_slave_mem_responder.sv
// AXI slave endpoint backed by a word-addressed local memory; FIXED/INCR/WRAP bursts,
// byte strobes, SLVERR on out-of-range beats. Write and read channels run independently.
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write address
//   W_DATA | WREADY high, accepting write beats until beat == LEN
//   W_RESP | BVALID high, holding the response until BREADY
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | RVALID high, presenting beats until the RLAST handshake
module axi_slave_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     S_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic [3:0]              S_AWLEN,
    input  logic [1:0]              S_AWBURST,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WLAST,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [ID_WIDTH-1:0]     S_BID,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ID_WIDTH-1:0]     S_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic [3:0]              S_ARLEN,
    input  logic [1:0]              S_ARBURST,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [ID_WIDTH-1:0]     S_RID,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RLAST,
    output logic                    S_RVALID,
    input  logic                    S_RREADY
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS) << BSH;
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] A_ONE     = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a - BASE_ADDR} < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> BSH);
    endfunction

    function automatic logic bad_wrap(input logic [3:0] len, input logic [1:0] burst);
        return (burst == 2'b10) &&
               !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    endfunction

    // WRAP keeps the upper bits of the aligned (LEN+1)*BYTES block and steps the lower ones
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [3:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = a + STEP;
        mask = ((ADDR_WIDTH'(len) + A_ONE) << BSH) - A_ONE;
        if (burst == 2'b00)
            return a;
        if (burst == 2'b10 && !bad_wrap(len, burst))
            return (a & ~mask) | (inc & mask);
        return inc;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [3:0]            w_len;
    logic [1:0]            w_burst;
    logic [3:0]            w_left;
    logic                  w_err;
    logic                  w_fire;
    logic                  w_bad;
    logic                  w_beat_err;

    assign w_fire     = S_WVALID && S_WREADY;
    assign w_bad      = !in_range(w_addr) || bad_wrap(w_len, w_burst);
    assign w_beat_err = w_bad || (S_WLAST != (w_left == 4'd0));

    always_ff @(posedge ACLK) begin
        if (w_fire && !w_bad)
            for (int b = 0; b < BYTES; b++)
                if (S_WSTRB[b])
                    mem[word_idx(w_addr)][b*8 +: 8] <= S_WDATA[b*8 +: 8];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state   <= W_IDLE;
            S_AWREADY <= 1'b0;
            S_WREADY  <= 1'b0;
            S_BVALID  <= 1'b0;
            S_BID     <= '0;
            S_BRESP   <= 2'b00;
            w_addr    <= '0;
            w_len     <= '0;
            w_burst   <= '0;
            w_left    <= '0;
            w_err     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    S_AWREADY <= 1'b1;
                    if (S_AWREADY && S_AWVALID) begin
                        S_AWREADY <= 1'b0;
                        S_WREADY  <= 1'b1;
                        S_BID     <= S_AWID;
                        w_addr    <= S_AWADDR;
                        w_len     <= S_AWLEN;
                        w_burst   <= S_AWBURST;
                        w_left    <= S_AWLEN;
                        w_err     <= 1'b0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_left == 4'd0) begin
                            S_WREADY <= 1'b0;
                            S_BVALID <= 1'b1;
                            S_BRESP  <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                            w_state  <= W_RESP;
                        end else begin
                            w_left <= w_left - 4'd1;
                            w_addr <= next_addr(w_addr, w_len, w_burst);
                            w_err  <= w_err || w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (S_BREADY) begin
                        S_BVALID  <= 1'b0;
                        S_BRESP   <= 2'b00;
                        S_AWREADY <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [1:0]            r_burst;
    logic [3:0]            r_left;
    logic [ADDR_WIDTH-1:0] r_next;
    logic [ADDR_WIDTH-1:0] r_sel_addr;
    logic [3:0]            r_sel_len;
    logic [1:0]            r_sel_burst;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_word;

    // One read port: the AR address when idle, otherwise the next beat's address
    assign r_next      = next_addr(r_addr, r_len, r_burst);
    assign r_sel_addr  = (r_state == R_IDLE) ? S_ARADDR  : r_next;
    assign r_sel_len   = (r_state == R_IDLE) ? S_ARLEN   : r_len;
    assign r_sel_burst = (r_state == R_IDLE) ? S_ARBURST : r_burst;
    assign r_err       = !in_range(r_sel_addr) || bad_wrap(r_sel_len, r_sel_burst);
    assign r_word      = mem[word_idx(r_sel_addr)];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= R_IDLE;
            S_ARREADY <= 1'b0;
            S_RVALID  <= 1'b0;
            S_RLAST   <= 1'b0;
            S_RID     <= '0;
            S_RDATA   <= '0;
            S_RRESP   <= 2'b00;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_left    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_ARREADY <= 1'b1;
                    if (S_ARREADY && S_ARVALID) begin
                        S_ARREADY <= 1'b0;
                        S_RID     <= S_ARID;
                        r_addr    <= S_ARADDR;
                        r_len     <= S_ARLEN;
                        r_burst   <= S_ARBURST;
                        r_left    <= S_ARLEN;
                        S_RVALID  <= 1'b1;
                        S_RLAST   <= (S_ARLEN == 4'd0);
                        S_RDATA   <= r_err ? '0 : r_word;
                        S_RRESP   <= r_err ? 2'b10 : 2'b00;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_RREADY) begin
                        if (S_RLAST) begin
                            S_RVALID  <= 1'b0;
                            S_RLAST   <= 1'b0;
                            S_RDATA   <= '0;
                            S_RRESP   <= 2'b00;
                            S_ARREADY <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_addr  <= r_next;
                            r_left  <= r_left - 4'd1;
                            S_RLAST <= (r_left == 4'd1);
                            S_RDATA <= r_err ? '0 : r_word;
                            S_RRESP <= r_err ? 2'b10 : 2'b00;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Randomized bench for axi_slave_mem_responder: a byte-level memory model and per-burst
// beat address lists produce expected B/R responses, checked every cycle they are valid.
module tb_axi_slave_mem_responder;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          IW   = 4;
    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [IW-1:0] S_AWID;
    logic [AW-1:0] S_AWADDR;
    logic [3:0]    S_AWLEN;
    logic [1:0]    S_AWBURST;
    logic          S_AWVALID;
    logic          S_AWREADY;
    logic [DW-1:0] S_WDATA;
    logic [3:0]    S_WSTRB;
    logic          S_WLAST;
    logic          S_WVALID;
    logic          S_WREADY;
    logic [IW-1:0] S_BID;
    logic [1:0]    S_BRESP;
    logic          S_BVALID;
    logic          S_BREADY;
    logic [IW-1:0] S_ARID;
    logic [AW-1:0] S_ARADDR;
    logic [3:0]    S_ARLEN;
    logic [1:0]    S_ARBURST;
    logic          S_ARVALID;
    logic          S_ARREADY;
    logic [IW-1:0] S_RID;
    logic [DW-1:0] S_RDATA;
    logic [1:0]    S_RRESP;
    logic          S_RLAST;
    logic          S_RVALID;
    logic          S_RREADY;

    always #5 ACLK = ~ACLK;

    axi_slave_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_WORDS(MW), .BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWBURST(S_AWBURST),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARBURST(S_ARBURST),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    logic [49:0] all_outs;
    assign all_outs = {S_AWREADY, S_WREADY, S_BID, S_BRESP, S_BVALID, S_ARREADY,
                       S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID};

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [31:0] mask;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t       exp_r[$];
    bexp_t       exp_b[$];
    rexp_t       er;
    bexp_t       eb;
    logic [31:0] mdl  [MW];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: handshake not seen within cycle budget (t=%0t)", name, $time);
    endtask

    function automatic logic legal_wrap(input int len);
        return len == 1 || len == 3 || len == 7 || len == 15;
    endfunction

    function automatic logic in_rng(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return la >= longint'(BASE) && la < longint'(BASE) + MW * 4;
    endfunction

    function automatic int midx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Byte address of beat i of a burst, from the burst rules
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int i);
        longint unsigned s, blk, base;
        s = start;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && legal_wrap(len)) begin
            blk  = longint'((len + 1) * 4);
            base = s - (s % blk);
            return 32'(base + (s - base + longint'(i * 4)) % blk);
        end
        return start + 32'(i * 4);
    endfunction

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (S_RVALID) begin
                if (exp_r.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL r_unexpected: RVALID high, expected no read beat (t=%0t)", $time);
                end else begin
                    er = exp_r[0];
                    check("rid",   64'(S_RID), 64'(er.id));
                    check("rdata", 64'(S_RDATA & er.mask), 64'(er.data & er.mask));
                    check("rresp", 64'(S_RRESP), 64'(er.resp));
                    check("rlast", 64'(S_RLAST), 64'(er.last));
                    if (S_RREADY) void'(exp_r.pop_front());
                end
            end
            if (S_BVALID) begin
                if (exp_b.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_unexpected: BVALID high, expected no response (t=%0t)", $time);
                end else begin
                    eb = exp_b[0];
                    check("bid",   64'(S_BID), 64'(eb.id));
                    check("bresp", 64'(S_BRESP), 64'(eb.resp));
                    if (S_BREADY) void'(exp_b.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int bdelay, input int stop_after);
        int          n;
        logic        err;
        logic [31:0] a;
        bexp_t       e;
        S_AWID = id; S_AWADDR = addr; S_AWLEN = 4'(len); S_AWBURST = burst; S_AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!S_AWREADY && n < 100) begin @(negedge ACLK); n++; end
        if (!S_AWREADY) begin timeout("aw_timeout"); S_AWVALID = 1'b0; return; end
        err = (burst == 2'b10) && !legal_wrap(len);
        for (int i = 0; i <= len; i++)
            if (!in_rng(beat_addr(addr, len, burst, i))) err = 1'b1;
        e.id = id;
        e.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(e);
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == stop_after) return;
            S_WDATA = wdat[i]; S_WSTRB = wstb[i]; S_WLAST = (i == len); S_WVALID = 1'b1;
            n = 0;
            @(negedge ACLK);
            while (!S_WREADY && n < 100) begin @(negedge ACLK); n++; end
            if (!S_WREADY) begin timeout("w_timeout"); S_WVALID = 1'b0; return; end
            a = beat_addr(addr, len, burst, i);
            if (in_rng(a) && !(burst == 2'b10 && !legal_wrap(len)))
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) mdl[midx(a)][b*8 +: 8] = wdat[i][b*8 +: 8];
            @(posedge ACLK); #1;
            S_WVALID = 1'b0; S_WLAST = 1'b0;
        end
        n = 0;
        @(negedge ACLK);
        while (!S_BVALID && n < 100) begin @(negedge ACLK); n++; end
        if (!S_BVALID) begin timeout("b_timeout"); return; end
        repeat (bdelay) @(posedge ACLK);
        @(posedge ACLK); #1 S_BREADY = 1'b1;
        @(posedge ACLK); #1 S_BREADY = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: RREADY low 5 cycles after the first beat
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int mode);
        int          n, beats, hold;
        logic        bw;
        logic [31:0] a;
        rexp_t       e;
        S_ARID = id; S_ARADDR = addr; S_ARLEN = 4'(len); S_ARBURST = burst; S_ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!S_ARREADY && n < 100) begin @(negedge ACLK); n++; end
        if (!S_ARREADY) begin timeout("ar_timeout"); S_ARVALID = 1'b0; return; end
        bw = (burst == 2'b10) && !legal_wrap(len);
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            e.id = id;
            e.last = (i == len);
            if (!in_rng(a)) begin
                e.data = '0; e.mask = '1; e.resp = 2'b10;
            end else if (bw) begin
                e.data = '0; e.mask = '0; e.resp = 2'b10;
            end else begin
                e.data = mdl[midx(a)]; e.mask = '1; e.resp = 2'b00;
            end
            exp_r.push_back(e);
        end
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        beats = 0; hold = 0; n = 0;
        while (beats <= len && n < 300) begin
            case (mode)
                0:       S_RREADY = 1'b1;
                1:       S_RREADY = 1'($urandom_range(0, 1));
                default: S_RREADY = !(beats == 1 && hold < 5);
            endcase
            @(negedge ACLK);
            if (S_RVALID && S_RREADY) beats++;
            else if (S_RVALID && beats == 1) hold++;
            @(posedge ACLK); #1;
            n++;
        end
        S_RREADY = 1'b0;
        if (beats <= len) timeout("r_timeout");
    endtask

    logic [3:0]  t_id;
    logic [1:0]  t_br;
    logic [31:0] t_ad;
    int          t_len;

    initial begin
        ARESET = 1'b1;
        S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
        S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0; S_BREADY = 1'b0;
        S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARBURST = '0; S_ARVALID = 1'b0;
        S_RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_outs", 64'(all_outs), 64'd0);
        ARESET = 1'b0;
        #1 check("awready_pre_edge", 64'(S_AWREADY), 64'd0);
        @(posedge ACLK); #1;
        check("awready_post_rst", 64'(S_AWREADY), 64'd1);
        check("arready_post_rst", 64'(S_ARREADY), 64'd1);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            do_write(4'(k), BASE + 32'(k * 64), 15, 2'b01, 0, -1);
        end

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(8'hA0 + i); wstb[i] = 4'hF; end
        do_write(4'h5, BASE + 32'h10, 3, 2'b01, 0, -1);
        check("lit_a2_model", 64'(mdl[midx(BASE + 32'h18)]), 64'h0000_00A2);
        do_read(4'h6, BASE + 32'h10, 3, 2'b01, 0);

        wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
        do_write(4'h7, BASE + 32'h40, 0, 2'b01, 0, -1);
        wdat[0] = 32'h1234_5678; wstb[0] = 4'b0101;
        do_write(4'h7, BASE + 32'h40, 0, 2'b01, 0, -1);
        check("lit_strb_model", 64'(mdl[16]), 64'hFF34_FF78);
        do_read(4'h8, BASE + 32'h40, 0, 2'b01, 0);

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(8'hB0 + i); wstb[i] = 4'hF; end
        do_write(4'h9, BASE + 32'h8, 3, 2'b10, 0, -1);
        check("lit_wrap_addr", 64'(beat_addr(BASE + 32'h8, 3, 2'b10, 2)), 64'(BASE));
        check("lit_wrap_model", 64'(mdl[0]), 64'h0000_00B2);
        do_read(4'hA, BASE + 32'h8, 3, 2'b10, 0);
        do_read(4'hB, BASE, 3, 2'b01, 0);

        do_read(4'hC, BASE + 32'(MW * 4), 1, 2'b01, 0);
        wdat[0] = 32'hDEAD_BEEF; wdat[1] = 32'hDEAD_BEEF; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(4'hD, BASE + 32'(MW * 4), 1, 2'b01, 3, -1);
        do_read(4'h3, BASE, 1, 2'b01, 0);
        do_read(4'hE, BASE + 32'(MW * 4 - 8), 3, 2'b01, 1);
        do_read(4'hF, 32'hFFFF_FFFC, 1, 2'b01, 0);

        do_read(4'h1, BASE + 32'h20, 3, 2'b01, 2);
        do_read(4'h2, BASE + 32'h30, 2, 2'b10, 0);

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(8'hC0 + i); wstb[i] = 4'hF; end
        do_write(4'h4, BASE + 32'h80, 3, 2'b01, 0, 2);
        ARESET = 1'b1;
        #1 check("rst_mid_outs", 64'(all_outs), 64'd0);
        exp_b.delete();
        exp_r.delete();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1 check("awready_pre_edge2", 64'(S_AWREADY), 64'd0);
        @(posedge ACLK); #1;
        check("awready_post_rst2", 64'(S_AWREADY), 64'd1);
        do_read(4'h5, BASE + 32'h80, 3, 2'b01, 0);

        for (int t = 0; t < 60; t++) begin
            t_id  = 4'($urandom_range(0, 15));
            t_br  = 2'($urandom_range(0, 2));
            t_len = $urandom_range(0, 15);
            t_ad  = BASE + 32'($urandom_range(0, MW + 3) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                if (t_br == 2'b10 && !legal_wrap(t_len)) t_len = 3;
                for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
                do_write(t_id, t_ad, t_len, t_br, $urandom_range(0, 2), -1);
            end else begin
                do_read(t_id, t_ad, t_len, t_br, 1);
            end
        end

        repeat (5) @(posedge ACLK);
        check("exp_r_drained", 64'(exp_r.size()), 64'd0);
        check("exp_b_drained", 64'(exp_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
